// File: rtl/ysyx_23060025_trap_seq.sv
// Trap/return sequencer owning the single CSR write port and the IFU redirect.
// Define TRAP_MSTATUS_EN to add the mstatus read-modify-write step.
module ysyx_23060025_trap_seq #(
  parameter int          DATA_WIDTH   = 32,
  parameter logic [11:0] MSTATUS_ADDR = 12'h300,
  parameter logic [11:0] MTVEC_ADDR   = 12'h305,
  parameter logic [11:0] MEPC_ADDR    = 12'h341,
  parameter logic [11:0] MCAUSE_ADDR  = 12'h342
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  inst_csr_wen,
  input  logic [11:0]           inst_csr_waddr,
  input  logic [DATA_WIDTH-1:0] inst_csr_wdata,
  output logic                  inst_csr_stall,
  input  logic                  trap_valid,
  input  logic [DATA_WIDTH-1:0] trap_cause,
  input  logic [DATA_WIDTH-1:0] trap_pc,
  input  logic                  mret_valid,
  output logic                  req_ready,
  output logic [11:0]           csr_raddr,
  input  logic [DATA_WIDTH-1:0] csr_rdata,
  output logic                  csr_wen,
  output logic [11:0]           csr_waddr,
  output logic [DATA_WIDTH-1:0] csr_wdata,
  output logic                  redirect_valid,
  output logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_EPC,
    S_W_CAUSE,
    S_W_STATUS,
    S_RD_VEC,
    S_RD_EPC,
    S_REDIRECT
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] epc_q, epc_d;
  logic [DATA_WIDTH-1:0] cause_q, cause_d;
  logic [DATA_WIDTH-1:0] target_q, target_d;
  logic                  is_mret_q, is_mret_d;
  logic [DATA_WIDTH-1:0] aligned;

  // Targets are forced to 4-byte alignment (mtvec mode bits dropped).
  assign aligned = {csr_rdata[DATA_WIDTH-1:2], 2'b00};

`ifdef TRAP_MSTATUS_EN
  logic [DATA_WIDTH-1:0] status_wdata;

  always_comb begin
    status_wdata        = csr_rdata;
    status_wdata[12:11] = 2'b11;
    if (is_mret_q) begin
      status_wdata[3] = csr_rdata[7];
      status_wdata[7] = 1'b1;
    end else begin
      status_wdata[7] = csr_rdata[3];
      status_wdata[3] = 1'b0;
    end
  end
`else
  logic unused_ok;
  assign unused_ok = ^{csr_rdata[1:0], is_mret_q};
`endif

  always_comb begin
    state_d   = state_q;
    epc_d     = epc_q;
    cause_d   = cause_q;
    target_d  = target_q;
    is_mret_d = is_mret_q;
    unique case (state_q)
      S_IDLE: begin
        priority case (1'b1)
          trap_valid: begin
            state_d   = S_W_EPC;
            epc_d     = trap_pc;
            cause_d   = trap_cause;
            is_mret_d = 1'b0;
          end
          mret_valid: begin
            state_d   = S_RD_EPC;
            is_mret_d = 1'b1;
          end
          default: ;
        endcase
      end
      S_W_EPC: state_d = S_W_CAUSE;
`ifdef TRAP_MSTATUS_EN
      S_W_CAUSE:  state_d = S_W_STATUS;
      S_W_STATUS: state_d = is_mret_q ? S_REDIRECT : S_RD_VEC;
`else
      S_W_CAUSE:  state_d = S_RD_VEC;
      S_W_STATUS: state_d = S_IDLE;
`endif
      S_RD_VEC: begin
        target_d = aligned;
        state_d  = S_REDIRECT;
      end
      S_RD_EPC: begin
        target_d = aligned;
`ifdef TRAP_MSTATUS_EN
        state_d  = S_W_STATUS;
`else
        state_d  = S_REDIRECT;
`endif
      end
      S_REDIRECT: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      epc_q     <= '0;
      cause_q   <= '0;
      target_q  <= '0;
      is_mret_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      epc_q     <= epc_d;
      cause_q   <= cause_d;
      target_q  <= target_d;
      is_mret_q <= is_mret_d;
    end
  end

  // Every strobe is gated by reset so an aborted sequence never commits.
  always_comb begin
    req_ready      = 1'b0;
    inst_csr_stall = 1'b0;
    busy           = 1'b0;
    csr_raddr      = '0;
    csr_wen        = 1'b0;
    csr_waddr      = '0;
    csr_wdata      = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    if (!reset) begin
      redirect_pc    = target_q;
      busy           = (state_q != S_IDLE);
      inst_csr_stall = (state_q != S_IDLE);
      unique case (state_q)
        S_IDLE: begin
          req_ready = 1'b1;
          csr_wen   = inst_csr_wen;
          csr_waddr = inst_csr_waddr;
          csr_wdata = inst_csr_wdata;
        end
        S_W_EPC: begin
          csr_wen   = 1'b1;
          csr_waddr = MEPC_ADDR;
          csr_wdata = epc_q;
        end
        S_W_CAUSE: begin
          csr_wen   = 1'b1;
          csr_waddr = MCAUSE_ADDR;
          csr_wdata = cause_q;
        end
`ifdef TRAP_MSTATUS_EN
        S_W_STATUS: begin
          csr_raddr = MSTATUS_ADDR;
          csr_wen   = 1'b1;
          csr_waddr = MSTATUS_ADDR;
          csr_wdata = status_wdata;
        end
`else
        S_W_STATUS: ;
`endif
        S_RD_VEC:   csr_raddr = MTVEC_ADDR;
        S_RD_EPC:   csr_raddr = MEPC_ADDR;
        S_REDIRECT: redirect_valid = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060025_trap_seq.sv
// Scoreboard bench for ysyx_23060025_trap_seq: CSR writes and redirects are
// queued when stimulus is driven and compared by a negedge monitor.
module tb_ysyx_23060025_trap_seq;

  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MTVEC   = 12'h305;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;
`ifdef TRAP_MSTATUS_EN
  localparam int TRAP_LAT = 5;
  localparam int MRET_LAT = 3;
`else
  localparam int TRAP_LAT = 4;
  localparam int MRET_LAT = 2;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        inst_csr_wen = 1'b0;
  logic [11:0] inst_csr_waddr = '0;
  logic [31:0] inst_csr_wdata = '0;
  logic        inst_csr_stall;
  logic        trap_valid = 1'b0;
  logic [31:0] trap_cause = '0;
  logic [31:0] trap_pc = '0;
  logic        mret_valid = 1'b0;
  logic        req_ready;
  logic [11:0] csr_raddr;
  logic [31:0] csr_rdata;
  logic        csr_wen;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;

  int errors = 0;
  int checks = 0;
  logic [43:0] wr_q[$];
  logic [31:0] rd_q[$];
  logic        prev_redir = 1'b0;
  logic        pre_en = 1'b0;
  logic [11:0] pre_addr = '0;
  logic [31:0] pre_data = '0;
  logic [31:0] csr_mem [0:4095];

  ysyx_23060025_trap_seq dut (
    .clock          (clock),
    .reset          (reset),
    .inst_csr_wen   (inst_csr_wen),
    .inst_csr_waddr (inst_csr_waddr),
    .inst_csr_wdata (inst_csr_wdata),
    .inst_csr_stall (inst_csr_stall),
    .trap_valid     (trap_valid),
    .trap_cause     (trap_cause),
    .trap_pc        (trap_pc),
    .mret_valid     (mret_valid),
    .req_ready      (req_ready),
    .csr_raddr      (csr_raddr),
    .csr_rdata      (csr_rdata),
    .csr_wen        (csr_wen),
    .csr_waddr      (csr_waddr),
    .csr_wdata      (csr_wdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  assign csr_rdata = csr_mem[csr_raddr];

  // CSR file stand-in, with a preload path used only while the DUT is idle
  always @(posedge clock) begin
    if (pre_en) csr_mem[pre_addr] = pre_data;
    else if (!reset && csr_wen) csr_mem[csr_waddr] = csr_wdata;
  end

  always @(negedge clock) begin
    logic [43:0] ew;
    logic [31:0] er;
    if (reset) begin
      prev_redir = 1'b0;
    end else begin
      if (csr_wen) begin
        checks++;
        if (wr_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got addr=%h data=%h, required no write",
                   csr_waddr, csr_wdata);
        end else begin
          ew = wr_q.pop_front();
          if ({csr_waddr, csr_wdata} !== ew) begin
            errors++;
            $display("FAIL csr_write: got addr=%h data=%h, required addr=%h data=%h",
                     csr_waddr, csr_wdata, ew[43:32], ew[31:0]);
          end
        end
      end
      if (redirect_valid) begin
        checks++;
        if (prev_redir) begin
          errors++;
          $display("FAIL redirect_twice: got 2 consecutive pulses, required 1");
        end
        checks++;
        if (rd_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_redirect: got pc=%h, required none", redirect_pc);
        end else begin
          er = rd_q.pop_front();
          if (redirect_pc !== er) begin
            errors++;
            $display("FAIL redirect_pc: got %h, required %h", redirect_pc, er);
          end
        end
      end
      prev_redir = redirect_valid;
    end
  end

  task automatic preload(input logic [11:0] a, input logic [31:0] d);
    pre_addr = a;
    pre_data = d;
    pre_en   = 1'b1;
    @(posedge clock); #1;
    pre_en   = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++;
    if ({req_ready, busy, inst_csr_stall, csr_wen, redirect_valid} !== 5'b0) begin
      errors++;
      $display("FAIL reset_strobes: got %b, required 00000",
               {req_ready, busy, inst_csr_stall, csr_wen, redirect_valid});
    end
    checks++;
    if (redirect_pc !== 32'h0) begin
      errors++;
      $display("FAIL reset_pc: got %h, required 0", redirect_pc);
    end
    checks++;
    if (csr_raddr !== 12'h0) begin
      errors++;
      $display("FAIL reset_raddr: got %h, required 0", csr_raddr);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if ({req_ready, busy} !== 2'b10) begin
      errors++;
      $display("FAIL post_reset: got ready,busy=%b, required 10", {req_ready, busy});
    end
    @(posedge clock); #1;
  endtask

  task automatic test_trap();
    preload(A_MSTATUS, 32'h0000_0008);
    preload(A_MTVEC, 32'h8000_1003);
    wr_q.push_back({A_MEPC, 32'h8000_0010});
    wr_q.push_back({A_MCAUSE, 32'd11});
`ifdef TRAP_MSTATUS_EN
    wr_q.push_back({A_MSTATUS, 32'h0000_1880});
`endif
    rd_q.push_back(32'h8000_1000);
    trap_valid = 1'b1;
    trap_pc    = 32'h8000_0010;
    trap_cause = 32'd11;
    @(negedge clock);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL trap_ready: got %b, required 1", req_ready);
    end
    @(posedge clock); #1;
    trap_valid = 1'b0;
    trap_pc    = 32'hdead_beef;
    trap_cause = 32'h7;
    for (int c = 1; c <= TRAP_LAT + 1; c++) begin
      @(negedge clock);
      checks++;
      if (redirect_valid !== (c == TRAP_LAT)) begin
        errors++;
        $display("FAIL trap_redirect_cycle%0d: got %b, required %b",
                 c, redirect_valid, c == TRAP_LAT);
      end
      if (c == 1) begin
        checks++;
        if ({inst_csr_stall, csr_wen, csr_waddr} !== {2'b11, A_MEPC}) begin
          errors++;
          $display("FAIL trap_w_epc: got stall,wen,addr=%b,%b,%h, required 1,1,%h",
                   inst_csr_stall, csr_wen, csr_waddr, A_MEPC);
        end
      end
      if (c == 2) begin
        checks++;
        if ({csr_wen, csr_waddr} !== {1'b1, A_MCAUSE}) begin
          errors++;
          $display("FAIL trap_w_cause: got wen,addr=%b,%h, required 1,%h",
                   csr_wen, csr_waddr, A_MCAUSE);
        end
      end
      if (c == TRAP_LAT - 1) begin
        checks++;
        if (csr_raddr !== A_MTVEC) begin
          errors++;
          $display("FAIL trap_rd_vec: got %h, required %h", csr_raddr, A_MTVEC);
        end
      end
      if (c == TRAP_LAT + 1) begin
        checks++;
        if ({busy, req_ready} !== 2'b01) begin
          errors++;
          $display("FAIL trap_done: got busy,ready=%b, required 01", {busy, req_ready});
        end
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_mret();
    preload(A_MEPC, 32'h8000_0014);
`ifdef TRAP_MSTATUS_EN
    wr_q.push_back({A_MSTATUS, 32'h0000_1888});
`endif
    rd_q.push_back(32'h8000_0014);
    mret_valid = 1'b1;
    @(posedge clock); #1;
    mret_valid = 1'b0;
    for (int c = 1; c <= MRET_LAT + 1; c++) begin
      @(negedge clock);
      checks++;
      if (redirect_valid !== (c == MRET_LAT)) begin
        errors++;
        $display("FAIL mret_redirect_cycle%0d: got %b, required %b",
                 c, redirect_valid, c == MRET_LAT);
      end
      if (c == 1) begin
        checks++;
        if (csr_raddr !== A_MEPC) begin
          errors++;
          $display("FAIL mret_rd_epc: got %h, required %h", csr_raddr, A_MEPC);
        end
      end
      if (c == MRET_LAT + 1) begin
        checks++;
        if ({busy, redirect_pc} !== {1'b0, 32'h8000_0014}) begin
          errors++;
          $display("FAIL mret_hold_pc: got busy=%b pc=%h, required 0 80000014",
                   busy, redirect_pc);
        end
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_trap_and_mret();
    wr_q.push_back({A_MEPC, 32'h8000_0020});
    wr_q.push_back({A_MCAUSE, 32'd2});
`ifdef TRAP_MSTATUS_EN
    wr_q.push_back({A_MSTATUS, 32'h0000_1880});
    wr_q.push_back({A_MSTATUS, 32'h0000_1888});
`endif
    rd_q.push_back(32'h8000_1000);
    rd_q.push_back(32'h8000_0020);
    trap_valid = 1'b1;
    mret_valid = 1'b1;
    trap_pc    = 32'h8000_0020;
    trap_cause = 32'd2;
    @(posedge clock); #1;
    trap_valid = 1'b0;
    for (int c = 1; c <= TRAP_LAT + 1; c++) begin
      @(negedge clock);
      checks++;
      if (req_ready !== (c == TRAP_LAT + 1)) begin
        errors++;
        $display("FAIL both_ready_cycle%0d: got %b, required %b",
                 c, req_ready, c == TRAP_LAT + 1);
      end
      if (c == 1) begin
        checks++;
        if (csr_waddr !== A_MEPC) begin
          errors++;
          $display("FAIL both_trap_first: got waddr=%h, required %h", csr_waddr, A_MEPC);
        end
      end
      @(posedge clock); #1;
    end
    mret_valid = 1'b0;
    for (int c = 1; c <= MRET_LAT + 1; c++) begin
      @(negedge clock);
      checks++;
      if (redirect_valid !== (c == MRET_LAT)) begin
        errors++;
        $display("FAIL both_mret_cycle%0d: got %b, required %b",
                 c, redirect_valid, c == MRET_LAT);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_stall();
    wr_q.push_back({A_MEPC, 32'h8000_0030});
    wr_q.push_back({A_MCAUSE, 32'd3});
`ifdef TRAP_MSTATUS_EN
    wr_q.push_back({A_MSTATUS, 32'h0000_1880});
`endif
    wr_q.push_back({A_MTVEC, 32'h8000_2000});
    rd_q.push_back(32'h8000_1000);
    trap_valid = 1'b1;
    trap_pc    = 32'h8000_0030;
    trap_cause = 32'd3;
    @(posedge clock); #1;
    trap_valid     = 1'b0;
    inst_csr_wen   = 1'b1;
    inst_csr_waddr = A_MTVEC;
    inst_csr_wdata = 32'h8000_2000;
    for (int c = 1; c <= TRAP_LAT + 1; c++) begin
      @(negedge clock);
      checks++;
      if (inst_csr_stall !== (c <= TRAP_LAT)) begin
        errors++;
        $display("FAIL stall_cycle%0d: got %b, required %b",
                 c, inst_csr_stall, c <= TRAP_LAT);
      end
      if (c == TRAP_LAT + 1) begin
        checks++;
        if ({csr_wen, csr_waddr} !== {1'b1, A_MTVEC}) begin
          errors++;
          $display("FAIL stall_release: got wen,addr=%b,%h, required 1,%h",
                   csr_wen, csr_waddr, A_MTVEC);
        end
      end
      @(posedge clock); #1;
    end
    inst_csr_wen = 1'b0;
  endtask

  task automatic test_reset_mid();
    wr_q.push_back({A_MEPC, 32'h8000_0040});
    trap_valid = 1'b1;
    trap_pc    = 32'h8000_0040;
    trap_cause = 32'd5;
    @(posedge clock); #1;
    trap_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if ({csr_wen, redirect_valid} !== 2'b00) begin
      errors++;
      $display("FAIL midreset_strobes: got wen,redir=%b, required 00",
               {csr_wen, redirect_valid});
    end
    @(posedge clock); #1;
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      checks++;
      if ({busy, req_ready, redirect_valid} !== 3'b010) begin
        errors++;
        $display("FAIL midreset_idle%0d: got busy,ready,redir=%b, required 010",
                 c, {busy, req_ready, redirect_valid});
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_back_to_back();
    wr_q.push_back({A_MTVEC, 32'h8000_3004});
    wr_q.push_back({A_MEPC, 32'h8000_0050});
    wr_q.push_back({A_MCAUSE, 32'd7});
`ifdef TRAP_MSTATUS_EN
    wr_q.push_back({A_MSTATUS, 32'h0000_1800});
    wr_q.push_back({A_MSTATUS, 32'h0000_1880});
`endif
    rd_q.push_back(32'h8000_3004);
    rd_q.push_back(32'h8000_0050);
    trap_pc        = 32'h8000_0050;
    trap_cause     = 32'd7;
    inst_csr_waddr = A_MTVEC;
    inst_csr_wdata = 32'h8000_3004;
    for (int c = 0; c <= TRAP_LAT + MRET_LAT + 2; c++) begin
      trap_valid   = (c == 0);
      inst_csr_wen = (c == 0);
      mret_valid   = (c == TRAP_LAT + 1);
      @(negedge clock);
      checks++;
      if (redirect_valid !== (c == TRAP_LAT || c == TRAP_LAT + MRET_LAT + 1)) begin
        errors++;
        $display("FAIL b2b_redirect_cycle%0d: got %b", c, redirect_valid);
      end
      @(posedge clock); #1;
    end
    trap_valid   = 1'b0;
    inst_csr_wen = 1'b0;
    mret_valid   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no completion, required finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_trap();
    test_mret();
    test_trap_and_mret();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (wr_q.size() != 0) begin
      errors++;
      $display("FAIL writes_left: got %0d pending, required 0", wr_q.size());
    end
    checks++;
    if (rd_q.size() != 0) begin
      errors++;
      $display("FAIL redirects_left: got %0d pending, required 0", rd_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
